// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - EX_MEM/MEM_WB field layout, write-back encodings and access FSM states for mem_stage
package mem_stage_pkg;

  localparam int EX_MEM_W  = 139;
  localparam int MEM_WB_W  = 38;

  localparam int WDATA_LSB    = 0;
  localparam int ALU_LSB      = 32;
  localparam int WREG_LSB     = 64;
  localparam int MEMREAD_BIT  = 69;
  localparam int MEMWRITE_BIT = 70;
  localparam int REGWRITE_BIT = 71;
  localparam int MEMTOREG_LSB = 72;
  localparam int PC4_LSB      = 74;
  localparam int LUDATA_LSB   = 106;
  localparam int LUOP_BIT     = 138;

  localparam int WB_DATA_LSB = 0;
  localparam int WB_REG_LSB  = 32;
  localparam int WB_RW_BIT   = 37;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_HOLD   = 2'b10
  } mem_state_e;

  // MemToReg 2'b11 falls back to the ALU result like 2'b00.
  function automatic logic [31:0] wb_select(input logic lu_op, input logic [31:0] lu_data,
                                            input logic [1:0] mem_to_reg, input logic [31:0] load_data,
                                            input logic [31:0] pc_plus4, input logic [31:0] alu);
    if (lu_op) return lu_data;
    case (mem_to_reg)
      MTR_MEM: return load_data;
      MTR_PC4: return pc_plus4;
      default: return alu;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - data-memory req/ack FSM with ack timeout, rdata buffer and sticky error
module mem_access_ctrl
  import mem_stage_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        access_i,
  input  logic        misalign_i,
  input  logic        uart_wait_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_stall_o,
  output logic        mem_err_o,
  output logic [31:0] load_data_o
);

  localparam logic [31:0] TIMEOUT = 32'(ACK_TIMEOUT);

  mem_state_e  state_q;
  logic [31:0] cnt_q;
  logic [31:0] buf_q;
  logic        err_q;

  logic        req;
  logic        stall;
  logic        done;
  logic        to_fire;
  logic        to_hit;
  logic [31:0] load_data;

  // cnt_q counts request cycles already spent, so the limit trips on the ACK_TIMEOUT-th one.
  assign to_hit = (TIMEOUT != 32'd0) && ((cnt_q + 32'd1) >= TIMEOUT);

  always_comb begin
    req       = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    to_fire   = 1'b0;
    load_data = mem_rdata_i;
    unique case (state_q)
      ST_IDLE:   req = access_i;
      ST_ACCESS: req = 1'b1;
      ST_HOLD: begin
        stall     = uart_wait_i;
        load_data = buf_q;
      end
      default: ;
    endcase
    if (req) begin
      to_fire = !mem_ack_i && to_hit;
      done    = mem_ack_i || to_fire;
      stall   = !done;
      if (to_fire) load_data = ERR_RDATA;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (to_fire || misalign_i) err_q <= 1'b1;
      unique case (state_q)
        ST_IDLE, ST_ACCESS: begin
          if (req) begin
            if (done) begin
              buf_q   <= load_data;
              cnt_q   <= '0;
              state_q <= uart_wait_i ? ST_HOLD : ST_IDLE;
            end else begin
              cnt_q   <= cnt_q + 32'd1;
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_HOLD: if (!uart_wait_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // An in-flight request is abandoned the moment reset rises, not at the next edge.
  assign mem_req_o   = req & ~rst_i;
  assign mem_stall_o = stall & ~rst_i;
  assign mem_err_o   = err_q;
  assign load_data_o = load_data;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: EX_MEM unpack, memory access, WB select, MEM_WB register (option MEM_ALIGN_CHECK_EN)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [EX_MEM_W-1:0] EX_MEM,
  input  logic                uart_wait,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
  output logic                mem_stall,
  output logic                mem_err,
  output logic [4:0]          EX_MEM_Rd,
  output logic                EX_MEM_RegWrite,
  output logic [31:0]         EX_MEM_RdData,
  output logic [MEM_WB_W-1:0] MEM_WB
);

  logic [31:0] wdata, alu, pc_plus4, lu_data, load_data, wb_data;
  logic [4:0]  write_reg;
  logic [1:0]  mem_to_reg;
  logic        mem_read, mem_write, reg_write, lu_op;
  logic        access_raw, access, misalign;

  assign wdata      = EX_MEM[WDATA_LSB +: 32];
  assign alu        = EX_MEM[ALU_LSB +: 32];
  assign write_reg  = EX_MEM[WREG_LSB +: 5];
  assign mem_read   = EX_MEM[MEMREAD_BIT];
  assign mem_write  = EX_MEM[MEMWRITE_BIT];
  assign reg_write  = EX_MEM[REGWRITE_BIT];
  assign mem_to_reg = EX_MEM[MEMTOREG_LSB +: 2];
  assign pc_plus4   = EX_MEM[PC4_LSB +: 32];
  assign lu_data    = EX_MEM[LUDATA_LSB +: 32];
  assign lu_op      = EX_MEM[LUOP_BIT];

  assign access_raw = mem_read | mem_write;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access_raw && (alu[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign access = access_raw & ~misalign;

  // Store wins when both MemRead and MemWrite are set.
  assign mem_we    = mem_write;
  assign mem_addr  = alu;
  assign mem_wdata = wdata;

  mem_access_ctrl #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .ERR_RDATA  (ERR_RDATA)
  ) u_ctrl (
    .clk_i      (clk),
    .rst_i      (reset),
    .access_i   (access),
    .misalign_i (misalign),
    .uart_wait_i(uart_wait),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata),
    .mem_req_o  (mem_req),
    .mem_stall_o(mem_stall),
    .mem_err_o  (mem_err),
    .load_data_o(load_data)
  );

  assign wb_data = wb_select(lu_op, lu_data, mem_to_reg, load_data, pc_plus4, alu);

  // Load-use is resolved by the hazard unit, so the forwarded value never needs load data.
  assign EX_MEM_Rd       = write_reg;
  assign EX_MEM_RegWrite = reg_write;
  assign EX_MEM_RdData   = wb_select(lu_op, lu_data, mem_to_reg, alu, pc_plus4, alu);

  logic [MEM_WB_W-1:0] mem_wb_q, mem_wb_d;

  assign mem_wb_d = {reg_write & ~misalign, write_reg, wb_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wb_q <= '0;
    end else if (!mem_stall && !uart_wait) begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign MEM_WB = mem_wb_q;

endmodule
